// File: rtl/div_32_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_32_seq
// Description : Iterative restoring divider, one quotient bit per clock,
//               signed/unsigned, with start/done handshake and DBZ flag.
// Revision    : 1.0 - initial release
// ============================================================================
module div_32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             BUSY,
    output logic             DONE,
    output logic             DBZ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ZERO = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    logic [WIDTH-1:0] it_rem, it_dvd, it_dvs;
    logic [WIDTH-1:0] it_shift, it_diff;
    logic             it_top, it_cout, it_bit;
    logic [WIDTH-1:0] it_rem_nxt, it_quo_nxt;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + c_one;
    endfunction

    assign a_neg = SIGNED & A[WIDTH-1];
    assign b_neg = SIGNED & B[WIDTH-1];
    assign a_abs = a_neg ? negate(A) : A;
    assign b_abs = b_neg ? negate(B) : B;

    // The start edge performs the first trial step directly on the operands.
    always_comb begin
        it_rem = rem_q;
        it_dvd = dvd_q;
        it_dvs = dvs_q;
        if (state_q == ST_IDLE) begin
            it_rem = '0;
            it_dvd = a_abs;
            it_dvs = b_abs;
        end
    end

    // Trial subtract through the adder's subtract path (~B, carry-in 1).
    // A bit shifted out of the remainder means the value exceeds the divisor.
    assign it_shift              = {it_rem[WIDTH-2:0], it_dvd[WIDTH-1]};
    assign it_top                = it_rem[WIDTH-1];
    assign {it_cout, it_diff}    = {1'b0, it_shift} + {1'b0, ~it_dvs} + {{WIDTH{1'b0}}, 1'b1};
    assign it_bit                = it_cout | it_top;
    assign it_rem_nxt            = it_bit ? it_diff : it_shift;
    assign it_quo_nxt            = {it_dvd[WIDTH-2:0], it_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (B == '0) begin
                        state_d = ST_ZERO;
                        dvd_d   = A;
                    end else begin
                        state_d = ST_BUSY;
                        rem_d   = it_rem_nxt;
                        dvd_d   = it_quo_nxt;
                        dvs_d   = b_abs;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_BUSY: begin
                rem_d = it_rem_nxt;
                dvd_d = it_quo_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == c_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    q_d     = qneg_q ? negate(it_quo_nxt) : it_quo_nxt;
                    r_d     = rneg_q ? negate(it_rem_nxt) : it_rem_nxt;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                end
            end
            ST_ZERO: begin
                state_d = ST_IDLE;
                q_d     = '1;
                r_d     = dvd_q;
                done_d  = 1'b1;
                dbz_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign BUSY = (state_q == ST_BUSY);
    assign DONE = done_q;
    assign DBZ  = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_32_seq
// Description : Directed self-checking bench for div_32_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        dbz;

    int total = 0;
    int bad   = 0;

    div_32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .SIGNED (sgn),
        .A      (a),
        .B      (b),
        .Q      (q),
        .R      (r),
        .BUSY   (busy),
        .DONE   (done),
        .DBZ    (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One operation: start edge, then wait for DONE while counting BUSY cycles.
    task automatic run_div(input string tag, input logic s, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] eq,
                           input logic [31:0] er, input logic edbz,
                           input int elat, input int ebusy);
        int  n;
        int  nbusy;
        bit  seen;
        sgn   = s;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        sgn   = ~s;
        a     = $urandom;
        b     = $urandom;
        n     = 0;
        nbusy = 0;
        seen  = 1'b0;
        while (!seen && n < 100) begin
            n++;
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
            if (!seen) tick();
        end
        chk({tag, " latency"}, 32'(n), 32'(elat));
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'(ebusy));
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " Q"}, q, eq);
        chk({tag, " R"}, r, er);
        chk({tag, " DBZ"}, {31'd0, dbz}, {31'd0, edbz});
        tick();
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int dcyc;
        logic [31:0] cq, cr;

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst Q", q, 32'd0);
        chk("rst R", r, 32'd0);
        chk("rst BUSY", {31'd0, busy}, 32'd0);
        chk("rst DONE", {31'd0, done}, 32'd0);
        chk("rst DBZ", {31'd0, dbz}, 32'd0);
        tick();

        run_div("u100_7",   1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 32, 31);
        run_div("s-7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32, 31);
        run_div("s7_-2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 32, 31);
        run_div("s-100_7",  1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 32, 31);
        run_div("umax_1",   1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 32, 31);
        run_div("smin_-1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 32, 31);
        run_div("umin_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 32, 31);
        run_div("u3_9",     1'b0, 32'd3,        32'd9,        32'd0,        32'd3,        1'b0, 32, 31);
        run_div("ubig",     1'b0, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 32, 31);
        run_div("u_hi_div", 1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1,        32'h7FFFFFFE, 1'b0, 32, 31);
        run_div("dbz5",     1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 2,  0);
        run_div("u8_2",     1'b0, 32'd8,        32'd2,        32'd4,        32'd0,        1'b0, 32, 31);

        // START pulsed mid-operation must be ignored.
        sgn   = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        ndone = 0;
        dcyc  = 0;
        cq    = '0;
        cr    = '0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                ndone++;
                dcyc = c;
                cq   = q;
                cr   = r;
            end
            if (c == 10) begin
                start = 1'b1;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("hs done_count", 32'(ndone), 32'd1);
        chk("hs done_cycle", 32'(dcyc), 32'd32);
        chk("hs Q", cq, 32'd14);
        chk("hs R", cr, 32'd2);

        // Reset in the middle of an operation.
        sgn   = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        chk("mid busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid BUSY", {31'd0, busy}, 32'd0);
        chk("mid Q", q, 32'd0);
        chk("mid R", r, 32'd0);
        chk("mid DONE", {31'd0, done}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("mid no_done", 32'(ndone), 32'd0);
        run_div("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
